// File: rtl/read_rw_pkg.sv
// ============================================================================
// read_rw_pkg : task/object types and register map for the RW read stage
// Rev 1.0
// ============================================================================
`default_nettype none

package read_rw_pkg;

  localparam int LOG_RW_WIDTH = 2;
  localparam int RW_OBJ_BITS  = 1 << (LOG_RW_WIDTH + 3);
  localparam int LOG_THREADS  = 4;

  typedef logic [LOG_THREADS-1:0] id_t;
  typedef logic [5:0]             cq_slot_t;
  typedef logic [RW_OBJ_BITS-1:0] rw_data_t;
  typedef logic [3:0]             task_type_t;

  localparam task_type_t TASK_TYPE_UNDO_LOG_RESTORE = 4'hF;

  typedef struct packed {
    task_type_t  ttype;
    logic [31:0] locale;
    logic [31:0] ts;
  } task_t;

  typedef struct packed {
    task_t    task_desc;
    cq_slot_t cq_slot;
    id_t      thread;
    rw_data_t object;
  } rw_read_t;

  typedef struct packed {
    task_t    task_desc;
    rw_data_t object;
    cq_slot_t cq_slot;
    id_t      thread;
  } rw_write_t;

  typedef struct packed {
    task_t    task_desc;
    cq_slot_t cq_slot;
    id_t      thread;
  } rw_pend_t;

  // Register offsets; reg_bus address bits [15:8] select the tile
  localparam logic [7:0] RW_BASE_ADDR  = 8'h40;
  localparam logic [7:0] RW_READ_COUNT = 8'h44;
  localparam logic [7:0] RW_READ_ERR   = 8'h48;

  function automatic logic [31:0] rw_addr(input logic [31:0] base, input logic [31:0] locale);
    return base + (locale << LOG_RW_WIDTH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/read_rw_reg_if.sv
// ============================================================================
// reg_bus_if : configuration/status bus, 1-cycle registered read
// Rev 1.0
// ============================================================================
`default_nettype none

interface reg_bus_if;
  logic        wvalid;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic        arvalid;
  logic [15:0] araddr;
  logic        rvalid;
  logic [31:0] rdata;

  modport slave (input wvalid, waddr, wdata, arvalid, araddr, output rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/read_rw_fifo.sv
// ============================================================================
// read_rw_fifo : shared synchronous FIFO, 2^LOG_DEPTH entries, show-ahead head
// Rev 1.0
// ============================================================================
`default_nettype none

module read_rw_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LOG_DEPTH:0]   r_count;

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == (LOG_DEPTH+1)'(DEPTH));
  assign empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (LOG_DEPTH+1)'(push) - (LOG_DEPTH+1)'(pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/read_rw.sv
// ============================================================================
// read_rw : issues RW locale reads, extracts objects, undo tasks bypass reads
// Rev 1.0
// ============================================================================
`default_nettype none

module read_rw
  import read_rw_pkg::*;
#(
  parameter int TILE_ID         = 0,
  parameter int LOG_OUTSTANDING = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         task_in_valid,
  output logic         task_in_ready,
  input  rw_read_t     task_in,
  output logic         arvalid,
  input  logic         arready,
  output logic [31:0]  araddr,
  output id_t          arid,
  input  logic         rvalid,
  output logic         rready,
  input  logic [511:0] rdata,
  input  id_t          rid,
  output logic         task_out_valid,
  input  logic         task_out_ready,
  output rw_write_t    task_out,
  reg_bus_if.slave     reg_bus
);

  localparam logic [7:0] c_tile_id = 8'(TILE_ID);

  logic        r_out_valid;
  rw_write_t   r_out;
  rw_write_t   w_next_out;
  logic [31:0] r_base;
  logic [31:0] r_rd_count;
  logic        r_err;
  logic        r_reg_rvalid;
  logic [15:0] r_reg_raddr;

  logic     w_is_undo, w_out_free, w_push, w_resp, w_orphan, w_bypass, w_mismatch;
  logic     w_pend_full, w_pend_empty, w_wsel;
  logic     w_unused_wdata;
  rw_pend_t w_push_data, w_head;
  rw_data_t w_obj;

  assign w_is_undo  = (task_in.task_desc.ttype == TASK_TYPE_UNDO_LOG_RESTORE);
  assign w_out_free = !r_out_valid || task_out_ready;

  assign arvalid       = task_in_valid && !w_is_undo && !w_pend_full;
  assign araddr        = rw_addr(r_base, task_in.task_desc.locale);
  assign arid          = task_in.thread;
  assign w_push        = arvalid && arready;

  // Orphan responses are always drained so the data array can never stall
  assign rready        = rvalid && (w_pend_empty || w_out_free);
  assign w_resp        = rvalid && rready && !w_pend_empty;
  assign w_orphan      = rvalid && w_pend_empty;
  assign w_mismatch    = w_resp && (rid != w_head.thread);

  assign w_bypass      = task_in_valid && w_is_undo && w_pend_empty && !w_resp && w_out_free;
  assign task_in_ready = w_push || w_bypass;

  assign w_push_data.task_desc = task_in.task_desc;
  assign w_push_data.cq_slot   = task_in.cq_slot;
  assign w_push_data.thread    = task_in.thread;

  read_rw_fifo #(
    .WIDTH     ($bits(rw_pend_t)),
    .LOG_DEPTH (LOG_OUTSTANDING)
  ) u_pend (
    .clk       (clk),
    .rstn      (rstn),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_resp),
    .head      (w_head),
    .full      (w_pend_full),
    .empty     (w_pend_empty)
  );

  generate
    if (LOG_RW_WIDTH < 6) begin : g_slice
      logic [5-LOG_RW_WIDTH:0] w_idx;
      assign w_idx = w_head.task_desc.locale[5-LOG_RW_WIDTH:0];
      assign w_obj = rdata[RW_OBJ_BITS*int'(w_idx) +: RW_OBJ_BITS];
    end else begin : g_whole
      assign w_obj = rdata;
    end
  endgenerate

  always_comb begin
    w_next_out = '0;
    if (w_resp) begin
      w_next_out.task_desc = w_head.task_desc;
      w_next_out.object    = w_obj;
      w_next_out.cq_slot   = w_head.cq_slot;
      w_next_out.thread    = w_head.thread;
    end else begin
      w_next_out.task_desc = task_in.task_desc;
      w_next_out.object    = task_in.object;
      w_next_out.cq_slot   = task_in.cq_slot;
      w_next_out.thread    = task_in.thread;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_resp || w_bypass) begin
      r_out_valid <= 1'b1;
      r_out       <= w_next_out;
    end else if (task_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign task_out_valid = r_out_valid;
  assign task_out       = r_out;

  assign w_wsel         = reg_bus.wvalid && (reg_bus.waddr[15:8] == c_tile_id);
  assign w_unused_wdata = ^reg_bus.wdata[31:30];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_base       <= '0;
      r_rd_count   <= '0;
      r_err        <= 1'b0;
      r_reg_rvalid <= 1'b0;
      r_reg_raddr  <= '0;
    end else begin
      if (w_push) r_rd_count <= r_rd_count + 32'd1;
      if (w_wsel && reg_bus.waddr[7:0] == RW_BASE_ADDR) r_base <= {reg_bus.wdata[29:0], 2'b00};
      // A new error in the same cycle as a clear wins
      if (w_wsel && reg_bus.waddr[7:0] == RW_READ_ERR) r_err <= 1'b0;
      if (w_mismatch || w_orphan) r_err <= 1'b1;
      r_reg_rvalid <= reg_bus.arvalid;
      r_reg_raddr  <= reg_bus.araddr;
    end
  end

  always_comb begin
    reg_bus.rdata = '0;
    if (r_reg_raddr[15:8] == c_tile_id) begin
      case (r_reg_raddr[7:0])
        RW_READ_COUNT: reg_bus.rdata = r_rd_count;
        RW_READ_ERR:   reg_bus.rdata = {31'b0, r_err};
        default:       reg_bus.rdata = '0;
      endcase
    end
  end

  assign reg_bus.rvalid = r_reg_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_read_rw.sv
// ============================================================================
// tb_read_rw : directed self-checking bench for read_rw
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_read_rw;
  import read_rw_pkg::*;

  logic         clk;
  logic         rstn;
  logic         task_in_valid;
  logic         task_in_ready;
  rw_read_t     task_in;
  logic         arvalid;
  logic         arready;
  logic [31:0]  araddr;
  id_t          arid;
  logic         rvalid;
  logic         rready;
  logic [511:0] rdata;
  id_t          rid;
  logic         task_out_valid;
  logic         task_out_ready;
  rw_write_t    task_out;

  reg_bus_if rb ();

  int checks = 0;
  int errors = 0;

  logic [511:0] line_pat;
  logic [511:0] line_a;

  read_rw #(
    .TILE_ID         (0),
    .LOG_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .task_in_valid  (task_in_valid),
    .task_in_ready  (task_in_ready),
    .task_in        (task_in),
    .arvalid        (arvalid),
    .arready        (arready),
    .araddr         (araddr),
    .arid           (arid),
    .rvalid         (rvalid),
    .rready         (rready),
    .rdata          (rdata),
    .rid            (rid),
    .task_out_valid (task_out_valid),
    .task_out_ready (task_out_ready),
    .task_out       (task_out),
    .reg_bus        (rb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rw_read_t mk(input task_type_t tt, input logic [31:0] loc,
                                  input cq_slot_t cq, input id_t th, input rw_data_t obj);
    rw_read_t t;
    t.task_desc.ttype  = tt;
    t.task_desc.locale = loc;
    t.task_desc.ts     = 32'h100 + loc;
    t.cq_slot          = cq;
    t.thread           = th;
    t.object           = obj;
    return t;
  endfunction

  task automatic reg_write(input logic [7:0] addr, input logic [31:0] data);
    rb.wvalid = 1'b1;
    rb.waddr  = {8'h00, addr};
    rb.wdata  = data;
    tick();
    rb.wvalid = 1'b0;
  endtask

  task automatic reg_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    rb.arvalid = 1'b1;
    rb.araddr  = {8'h00, addr};
    tick();
    rb.arvalid = 1'b0;
    chk(tag, {31'b0, rb.rvalid, rb.rdata}, {31'b0, 1'b1, exp});
  endtask

  task automatic push_read(input logic [31:0] loc, input cq_slot_t cq, input id_t th);
    task_in       = mk(4'h1, loc, cq, th, '0);
    task_in_valid = 1'b1;
    tick();
    task_in_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; task_in_valid = 1'b0; task_in = '0; arready = 1'b1;
    rvalid = 1'b0; rdata = '0; rid = '0; task_out_ready = 1'b1;
    rb.wvalid = 1'b0; rb.waddr = '0; rb.wdata = '0; rb.arvalid = 1'b0; rb.araddr = '0;
    for (int w = 0; w < 16; w++) line_pat[w*32 +: 32] = 32'h1000_0000 + 32'(w);
    line_a = line_pat;
    line_a[3*32 +: 32] = 32'hDEAD_BEEF;

    #12;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_out_valid", task_out_valid, 0);
    chk("rst_in_ready", task_in_ready, 0);
    tick();
    rstn = 1'b1;
    tick();

    // Base address and slicing
    reg_write(RW_BASE_ADDR, 32'h0000_0400);
    reg_check("count_init", RW_READ_COUNT, 32'd0);
    task_in = mk(4'h1, 32'h13, 6'd7, 4'd3, '0);
    task_in_valid = 1'b1;
    #1;
    chk("a_arvalid", arvalid, 1);
    chk("a_araddr", araddr, 32'h104C);
    chk("a_arid", arid, 3);
    chk("a_in_ready", task_in_ready, 1);
    tick();
    task_in_valid = 1'b0;
    rdata = line_a; rvalid = 1'b1; rid = 4'd3;
    #1;
    chk("a_rready", rready, 1);
    tick();
    rvalid = 1'b0;
    chk("a_out_valid", task_out_valid, 1);
    chk("a_object", task_out.object, 32'hDEAD_BEEF);
    chk("a_cq", task_out.cq_slot, 7);
    chk("a_thread", task_out.thread, 3);
    chk("a_locale", task_out.task_desc.locale, 32'h13);
    tick();
    chk("a_drained", task_out_valid, 0);

    // Outstanding limit: four accepted, fifth waits for a pop
    rdata = line_pat;
    for (int i = 0; i < 4; i++) begin
      task_in = mk(4'h1, 32'(i), 6'(i), 4'(i), '0);
      task_in_valid = 1'b1;
      #1;
      chk("lim_in_ready", task_in_ready, 1);
      tick();
    end
    task_in = mk(4'h1, 32'd4, 6'd4, 4'd4, '0);
    #1;
    chk("lim_5th_blocked", task_in_ready, 0);
    chk("lim_5th_arvalid", arvalid, 0);
    for (int i = 0; i < 5; i++) begin
      rvalid = 1'b1; rid = 4'(i);
      #1;
      chk("lim_5th_ready", task_in_ready, (i == 1) ? 64'd1 : 64'd0);
      tick();
      if (i == 1) task_in_valid = 1'b0;
      chk("lim_out_valid", task_out_valid, 1);
      chk("lim_out_object", task_out.object, 32'h1000_0000 + 32'(i));
      chk("lim_out_thread", task_out.thread, 4'(i));
    end
    rvalid = 1'b0;
    tick();
    reg_check("lim_count", RW_READ_COUNT, 32'd6);

    // Undo bypass must wait behind the outstanding read
    push_read(32'd5, 6'd2, 4'd1);
    task_in = mk(TASK_TYPE_UNDO_LOG_RESTORE, 32'd9, 6'd9, 4'd6, 32'h55);
    task_in_valid = 1'b1;
    #1;
    chk("undo_stall", task_in_ready, 0);
    chk("undo_no_ar", arvalid, 0);
    tick();
    rvalid = 1'b1; rid = 4'd1;
    #1;
    chk("undo_stall_resp", task_in_ready, 0);
    tick();
    rvalid = 1'b0;
    chk("undo_first_obj", task_out.object, 32'h1000_0005);
    chk("undo_first_thread", task_out.thread, 1);
    chk("undo_accept", task_in_ready, 1);
    tick();
    task_in_valid = 1'b0;
    chk("undo_out_valid", task_out_valid, 1);
    chk("undo_out_obj", task_out.object, 32'h55);
    chk("undo_out_thread", task_out.thread, 6);
    chk("undo_out_cq", task_out.cq_slot, 9);
    tick();
    chk("undo_drained", task_out_valid, 0);
    reg_check("undo_count", RW_READ_COUNT, 32'd7);

    // Backpressure holds the output and blocks rready
    task_out_ready = 1'b0;
    push_read(32'd6, 6'd3, 4'd2);
    push_read(32'd7, 6'd4, 4'd4);
    rvalid = 1'b1; rid = 4'd2;
    #1;
    chk("bp_rready_first", rready, 1);
    tick();
    rid = 4'd4;
    chk("bp_first_obj", task_out.object, 32'h1000_0006);
    chk("bp_rready_hold", rready, 0);
    tick();
    chk("bp_stable_valid", task_out_valid, 1);
    chk("bp_stable_obj", task_out.object, 32'h1000_0006);
    task_out_ready = 1'b1;
    #1;
    chk("bp_rready_release", rready, 1);
    tick();
    rvalid = 1'b0;
    chk("bp_b2b_valid", task_out_valid, 1);
    chk("bp_b2b_obj", task_out.object, 32'h1000_0007);
    chk("bp_b2b_thread", task_out.thread, 4);
    tick();
    chk("bp_drained", task_out_valid, 0);

    // Response id mismatch sets the sticky error but data is used
    reg_check("err_clean", RW_READ_ERR, 32'd0);
    push_read(32'd8, 6'd5, 4'd2);
    rvalid = 1'b1; rid = 4'd5;
    tick();
    rvalid = 1'b0;
    chk("mm_out_valid", task_out_valid, 1);
    chk("mm_out_obj", task_out.object, 32'h1000_0008);
    chk("mm_out_thread", task_out.thread, 2);
    reg_check("mm_err_set", RW_READ_ERR, 32'd1);
    reg_write(RW_READ_ERR, 32'd0);
    reg_check("mm_err_clr", RW_READ_ERR, 32'd0);

    // Reset mid-operation, later responses become orphans
    task_out_ready = 1'b0;
    push_read(32'd10, 6'd1, 4'd1);
    push_read(32'd11, 6'd2, 4'd2);
    rvalid = 1'b1; rid = 4'd1;
    tick();
    rvalid = 1'b0;
    chk("rst_pre_valid", task_out_valid, 1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_out_valid", task_out_valid, 0);
    chk("rst_mid_out", task_out, '0);
    chk("rst_mid_arvalid", arvalid, 0);
    tick();
    rstn = 1'b1;
    tick();
    reg_check("rst_count", RW_READ_COUNT, 32'd0);
    rvalid = 1'b1; rid = 4'd2;
    #1;
    chk("orphan1_rready", rready, 1);
    tick();
    chk("orphan1_no_out", task_out_valid, 0);
    rid = 4'd1;
    #1;
    chk("orphan2_rready", rready, 1);
    tick();
    rvalid = 1'b0;
    chk("orphan2_no_out", task_out_valid, 0);
    reg_check("orphan_err", RW_READ_ERR, 32'd1);
    task_out_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/read_rw.md
Name: read_rw

Overview:
- Read-side counterpart of the RW write stage. Accepts RW tasks from the task unit and issues a read of the task's locale object to the tile's RW data array, bypassing the tags.
- Extracts the object from the returned 512-bit line and emits an rw_write_t (task, object, cq_slot, thread) toward the RW worker/write stage.
- Undo-log-restore tasks already carry their object, so they skip the read and go straight to the output stage.

Parameters:
TILE_ID, 0, tile index, passed through for debug and reg_bus identification
LOG_OUTSTANDING, 2, log2 of maximum in-flight reads (depth of the pending FIFO)

Ports:
clk  in  1  clock
rstn  in  1  reset; one clock, asynchronous, active-low
task_in_valid  in  1  incoming task valid
task_in_ready  out  1  incoming task accepted this cycle
task_in  in  rw_read_t  {task_desc, cq_slot, thread, object}; object is meaningful only for TASK_TYPE_UNDO_LOG_RESTORE
arvalid  out  1  read request valid
arready  in  1  data array accepts the read
araddr  out  32  byte address into the data array
arid  out  id_t  thread id of the request
rvalid  in  1  read data valid
rready  out  1  read data consumed
rdata  in  512  returned line
rid  in  id_t  thread id of the response
task_out_valid  out  1  output valid (registered)
task_out_ready  in  1  downstream ready
task_out  out  rw_write_t  task with object filled in
reg_bus  inout  reg_bus_t  configuration and status bus

Behaviour:
- Reset values: arvalid=0, rready=0, task_out_valid=0, task_in_ready=0. Pending FIFO empty, base_rw_addr=0, rd_count=0, err_sticky=0.
- Read issue:
  - arvalid = task_in_valid & ttype!=UNDO_LOG_RESTORE & !pending_full.
  - araddr = base_rw_addr + (locale << LOG_RW_WIDTH), computed mod 2^32. arid = task_in.thread.
  - task_in_ready = arvalid & arready.
  - On that handshake, push {task_desc, cq_slot, thread} into the pending FIFO (depth 2^LOG_OUTSTANDING) and increment rd_count (32-bit, wraps).
- Undo bypass:
  - An undo-log-restore task is accepted only when the pending FIFO is empty, no response is being consumed this cycle, and the output slot is free (!task_out_valid | task_out_ready).
  - On accept: task_in_ready=1 and the output register loads {task_desc, task_in.object, cq_slot, thread}.
  - Otherwise the task stalls; ordering with earlier reads is preserved.
- Response:
  - rready = rvalid & (!task_out_valid | task_out_ready) when the pending FIFO is non-empty.
  - On rvalid&rready: pop the head and load the output register. The object is the slice of rdata at index locale[(5-LOG_RW_WIDTH):0] × 2^(LOG_RW_WIDTH+3) bits, width 2^(LOG_RW_WIDTH+3). For LOG_RW_WIDTH=6 the object is the whole line.
  - Responses return in order. If rid != head.thread, set err_sticky; data is still used.
- Orphan response: rvalid with the pending FIFO empty (e.g. after reset mid-operation) → rready=1, data dropped, err_sticky set. The array is never hung.
- Latency: response handshake at cycle N gives task_out_valid=1 at N+1. task_out_valid holds until task_out_ready. The output register reloads in the same cycle it drains (full throughput).
- Simultaneous events:
  - Push and pop of the pending FIFO in the same cycle are allowed, including when full (push only if !pending_full evaluated before the pop, for simplicity).
  - An undo bypass and a response load never coincide (the bypass requires no response consumption that cycle).
- reg_bus:
  - Write RW_BASE_ADDR → base_rw_addr = {wdata[29:0], 2'b00}.
  - Read RW_READ_COUNT → rd_count. Read RW_READ_ERR → {31'b0, err_sticky}. Write RW_READ_ERR clears err_sticky.
  - rvalid is registered from arvalid (1-cycle read latency); rdata is muxed by the registered address, 0 for unknown addresses.
- Reset mid-operation: all state cleared asynchronously. In-flight responses are then handled as orphans.

Decomposition:
- swarm package: rw_read_t typedef, and the RW_READ_COUNT and RW_READ_ERR register addresses alongside RW_BASE_ADDR. LOG_RW_WIDTH, id_t, rw_write_t and TASK_TYPE_UNDO_LOG_RESTORE stay where they are.
- The pending queue is the existing shared fifo sub-module instantiated with LOG_DEPTH=LOG_OUTSTANDING. No new sub-module.

Test Plan:
- Base address and slicing: base=0x1000, LOG_RW_WIDTH=2, locale=0x13, thread=3 → araddr=0x104C, arid=3. Return rdata with word 3 = 0xDEADBEEF → task_out.object=0xDEADBEEF at cycle N+1, with cq_slot and thread echoed.
- Outstanding limit: issue 5 reads with arready=1 and rvalid held low → 4 accepted, task_in_ready=0 on the 5th. Return 4 responses → outputs appear in issue order; then the 5th issues.
- Undo bypass ordering: read A outstanding, then undo task U (object=0x55) → U stalls. After A's response, task_out emits A then U. rd_count increments by 1.
- Backpressure: task_out_ready=0 with task_out_valid=1 → rready=0 and task_out is stable. Release → back-to-back outputs at one per cycle.
- rid mismatch: head thread=2, rid=5 → output still produced and RW_READ_ERR reads 1. Write RW_READ_ERR → reads 0.
- Reset mid-op: 2 reads in flight, pulse rstn low → all outputs 0 immediately. The two later responses are accepted with rready=1, no task_out is produced, and err_sticky=1.
